// File: rtl/alu_pipe_if.sv
// alu_pipe_if: operand/result handshake bundle for alu_pipe.
//   in_valid/in_ready : operand+opcode handshake (a, b, ctr)
//   out_valid/out_ready: result handshake (out, flags {N,Z,C,V}, err)
// master = producer of operands / consumer of results, slave = the ALU.
interface alu_pipe_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       ctr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic [3:0]       flags;
  logic             err;

  modport master (
    output in_valid, a, b, ctr, out_ready,
    input  in_ready, out_valid, out, flags, err
  );

  modport slave (
    input  in_valid, a, b, ctr, out_ready,
    output in_ready, out_valid, out, flags, err
  );
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage WIDTH-bit ALU with valid/ready handshake.
//   ck, rst_n : clock (rising edge), asynchronous active-low reset
//   bus       : alu_pipe_if slave (operands in, result + {N,Z,C,V} + err out)
// S1 holds the captured operands and the shift-add multiplier state; S2 is
// the output register. A persistent carry (creg) feeds ADC/SBB and is
// updated whenever a result loads S2.
module alu_pipe #(
  parameter int unsigned WIDTH  = 8,
  parameter bit          MUL_EN = 1'b1
) (
  input  logic        ck,
  input  logic        rst_n,
  alu_pipe_if.slave   bus
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_ADC  = 4'b0010;
  localparam logic [3:0] OP_SBB  = 4'b0011;
  localparam logic [3:0] OP_MULL = 4'b0100;
  localparam logic [3:0] OP_MULH = 4'b0101;
  localparam logic [3:0] OP_AND  = 4'b1000;
  localparam logic [3:0] OP_OR   = 4'b1001;
  localparam logic [3:0] OP_XOR  = 4'b1010;
  localparam logic [3:0] OP_NOT  = 4'b1011;
  localparam logic [3:0] OP_SHR  = 4'b1100;
  localparam logic [3:0] OP_SHL  = 4'b1101;
  localparam logic [3:0] OP_ROR  = 4'b1110;
  localparam logic [3:0] OP_ROL  = 4'b1111;

  // S1 state
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [3:0]       ctr_q, ctr_d;
  logic [PW-1:0]    prod_q, prod_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             mul_done_q, mul_done_d;

  // S2 state and carry register
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [3:0]       flags_q, flags_d;
  logic             err_q, err_d;
  logic             creg_q, creg_d;

  // Execute results
  logic [WIDTH:0]   ext_c;
  logic [WIDTH-1:0] res_c;
  logic             c_c;
  logic             v_c;
  logic             ill_c;
  logic [3:0]       flags_c;

  logic             is_mul_c;
  logic             s1_done_c;
  logic             load_s2_c;
  logic             in_ready_c;
  logic             accept_c;
  logic [PW-1:0]    partial_c;

  // Handshake: S1 frees up in the same edge its result moves into S2
  assign is_mul_c   = MUL_EN && ((ctr_q == OP_MULL) || (ctr_q == OP_MULH));
  assign s1_done_c  = !is_mul_c || mul_done_q;
  assign load_s2_c  = s1_valid_q && s1_done_c && (!out_valid_q || bus.out_ready);
  assign in_ready_c = !s1_valid_q || load_s2_c;
  assign accept_c   = bus.in_valid && in_ready_c;

  // One partial product per cycle, selected by the multiplier bit at cnt_q
  assign partial_c  = b_q[cnt_q] ? (PW'(a_q) << cnt_q) : '0;

  // Result and flag generation from the S1 operands
  always_comb begin
    ext_c = '0;
    res_c = '0;
    c_c   = creg_q;
    v_c   = 1'b0;
    ill_c = 1'b0;
    case (ctr_q)
      OP_ADD: begin
        ext_c = {1'b0, a_q} + {1'b0, b_q};
        res_c = ext_c[WIDTH-1:0];
        c_c   = ext_c[WIDTH];
        v_c   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (ext_c[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        ext_c = {1'b0, a_q} - {1'b0, b_q};
        res_c = ext_c[WIDTH-1:0];
        c_c   = ext_c[WIDTH];
        v_c   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (ext_c[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_ADC: begin
        ext_c = {1'b0, a_q} + {1'b0, b_q} + (WIDTH+1)'(creg_q);
        res_c = ext_c[WIDTH-1:0];
        c_c   = ext_c[WIDTH];
        v_c   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (ext_c[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SBB: begin
        ext_c = {1'b0, a_q} - {1'b0, b_q} - (WIDTH+1)'(creg_q);
        res_c = ext_c[WIDTH-1:0];
        c_c   = ext_c[WIDTH];
        v_c   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (ext_c[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_MULL: begin
        if (MUL_EN) begin
          res_c = prod_q[WIDTH-1:0];
          c_c   = |prod_q[PW-1:WIDTH];
        end else begin
          ill_c = 1'b1;
        end
      end
      OP_MULH: begin
        if (MUL_EN) begin
          res_c = prod_q[PW-1:WIDTH];
          c_c   = 1'b0;
        end else begin
          ill_c = 1'b1;
        end
      end
      OP_AND: res_c = a_q & b_q;
      OP_OR:  res_c = a_q | b_q;
      OP_XOR: res_c = a_q ^ b_q;
      OP_NOT: res_c = ~a_q;
      OP_SHR: begin
        res_c = {1'b0, a_q[WIDTH-1:1]};
        c_c   = a_q[0];
      end
      OP_SHL: begin
        res_c = {a_q[WIDTH-2:0], 1'b0};
        c_c   = a_q[WIDTH-1];
      end
      OP_ROR: begin
        res_c = {a_q[0], a_q[WIDTH-1:1]};
        c_c   = a_q[0];
      end
      OP_ROL: begin
        res_c = {a_q[WIDTH-2:0], a_q[WIDTH-1]};
        c_c   = a_q[WIDTH-1];
      end
      default: ill_c = 1'b1;
    endcase
    flags_c = {res_c[WIDTH-1], (res_c == '0), c_c, v_c};
  end

  // Next-state for S1, multiplier, S2 and creg
  always_comb begin
    s1_valid_d  = s1_valid_q;
    a_d         = a_q;
    b_d         = b_q;
    ctr_d       = ctr_q;
    prod_d      = prod_q;
    cnt_d       = cnt_q;
    mul_done_d  = mul_done_q;
    out_valid_d = out_valid_q;
    out_d       = out_q;
    flags_d     = flags_q;
    err_d       = err_q;
    creg_d      = creg_q;

    if (s1_valid_q && is_mul_c && !mul_done_q) begin
      prod_d = prod_q + partial_c;
      if (cnt_q == CNT_LAST) begin
        cnt_d      = '0;
        mul_done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    if (load_s2_c) begin
      s1_valid_d = 1'b0;
    end

    // A new accept overrides the clear above (back-to-back issue)
    if (accept_c) begin
      s1_valid_d = 1'b1;
      a_d        = bus.a;
      b_d        = bus.b;
      ctr_d      = bus.ctr;
      prod_d     = '0;
      cnt_d      = '0;
      mul_done_d = 1'b0;
    end

    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    if (load_s2_c) begin
      out_valid_d = 1'b1;
      out_d       = res_c;
      flags_d     = flags_c;
      err_d       = ill_c;
      creg_d      = c_c;
    end
  end

  // State registers
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      ctr_q       <= '0;
      prod_q      <= '0;
      cnt_q       <= '0;
      mul_done_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      flags_q     <= '0;
      err_q       <= 1'b0;
      creg_q      <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      a_q         <= a_d;
      b_q         <= b_d;
      ctr_q       <= ctr_d;
      prod_q      <= prod_d;
      cnt_q       <= cnt_d;
      mul_done_q  <= mul_done_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      flags_q     <= flags_d;
      err_q       <= err_d;
      creg_q      <= creg_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;
  assign bus.flags     = flags_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed + randomized check of alu_pipe (WIDTH=8) against an
// arithmetic reference model; a second instance covers MUL_EN=0.
module tb_alu_pipe;

  localparam int unsigned W = 8;
  localparam int M = 1 << W;
  localparam int H = 1 << (W - 1);

  typedef struct packed {
    logic         err;
    logic [3:0]   flags;
    logic [W-1:0] out;
  } exp_t;

  logic ck;
  logic rst_n;

  alu_pipe_if #(.WIDTH(W)) bus ();
  alu_pipe_if #(.WIDTH(W)) bus0 ();

  alu_pipe #(.WIDTH(W), .MUL_EN(1'b1)) dut  (.ck(ck), .rst_n(rst_n), .bus(bus));
  alu_pipe #(.WIDTH(W), .MUL_EN(1'b0)) dut0 (.ck(ck), .rst_n(rst_n), .bus(bus0));

  initial ck = 1'b0;
  always #5 ck = ~ck;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  bit   acc = 1'b0;
  bit   rnd_ready = 1'b0;
  bit   held = 1'b0;
  exp_t held_v;
  exp_t expq[$];
  logic m_creg = 1'b0;

  // Reference: results from integer arithmetic on the opcode definitions
  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic cr, input bit mul_en);
    int ua, ub, sa, sb, r, s, p;
    logic c, v, il;
    exp_t e;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= H) ? ua - M : ua;
    sb = (ub >= H) ? ub - M : ub;
    c = cr; v = 1'b0; il = 1'b0; r = 0; s = 0;
    case (op)
      4'd0: begin r = ua + ub; c = (r >= M); s = sa + sb; v = (s < -H) || (s >= H); end
      4'd1: begin r = ua - ub; c = (r < 0);  s = sa - sb; v = (s < -H) || (s >= H); end
      4'd2: begin r = ua + ub + int'(cr); c = (r >= M); s = sa + sb + int'(cr); v = (s < -H) || (s >= H); end
      4'd3: begin r = ua - ub - int'(cr); c = (r < 0);  s = sa - sb - int'(cr); v = (s < -H) || (s >= H); end
      4'd4, 4'd5: begin
        if (mul_en) begin
          p = ua * ub;
          if (op == 4'd4) begin r = p % M; c = ((p / M) != 0); end
          else            begin r = p / M; c = 1'b0; end
        end else il = 1'b1;
      end
      4'd8:  r = int'(a & b);
      4'd9:  r = int'(a | b);
      4'd10: r = int'(a ^ b);
      4'd11: r = M - 1 - ua;
      4'd12: begin r = ua / 2; c = ((ua % 2) == 1); end
      4'd13: begin r = ua * 2; c = (ua >= H); end
      4'd14: begin r = ua / 2 + (ua % 2) * H; c = ((ua % 2) == 1); end
      4'd15: begin r = ua * 2 + ua / H; c = (ua >= H); end
      default: il = 1'b1;
    endcase
    if (il) begin r = 0; c = cr; v = 1'b0; end
    r = ((r % M) + M) % M;
    e.out   = W'(r);
    e.err   = il;
    e.flags = {e.out[W-1], (e.out == '0), c, v};
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: check retire/hold at negedge, log accepts, advance past posedge
  task automatic tick();
    exp_t e;
    acc = 1'b0;
    @(negedge ck);
    if (rst_n) begin
      if (held && bus.out_valid) begin
        chk("hold_out",   32'(bus.out),   32'(held_v.out));
        chk("hold_flags", 32'(bus.flags), 32'(held_v.flags));
        chk("hold_err",   32'(bus.err),   32'(held_v.err));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (expq.size() == 0) begin
          chk("extra_result", 32'(bus.out_valid), 32'd0);
        end else begin
          e = expq.pop_front();
          chk("res_out",   32'(bus.out),   32'(e.out));
          chk("res_flags", 32'(bus.flags), 32'(e.flags));
          chk("res_err",   32'(bus.err),   32'(e.err));
        end
        held = 1'b0;
      end else begin
        held   = bus.out_valid;
        held_v = {bus.err, bus.flags, bus.out};
      end
      if (bus.in_valid && bus.in_ready) begin
        e = model(bus.ctr, bus.a, bus.b, m_creg, 1'b1);
        m_creg = e.flags[1];
        expq.push_back(e);
        acc = 1'b1;
        acc_cyc = cyc;
      end
    end
    @(posedge ck);
    cyc++;
    #1;
    if (rnd_ready) bus.out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bit got;
    got = 1'b0;
    bus.in_valid = 1'b1;
    bus.ctr = op;
    bus.a = a;
    bus.b = b;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (acc) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("send_timeout", 32'(got), 32'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (expq.size() == 0 && !bus.out_valid) break;
      tick();
    end
    chk("drain_empty", 32'(expq.size()), 32'd0);
  endtask

  task automatic model_reset();
    expq.delete();
    m_creg = 1'b0;
    held = 1'b0;
  endtask

  int c1;

  initial begin
    rst_n = 1'b1;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.ctr = '0; bus.out_ready = 1'b1;
    bus0.in_valid = 1'b0; bus0.a = '0; bus0.b = '0; bus0.ctr = '0; bus0.out_ready = 1'b1;

    // Reset values
    #2 rst_n = 1'b0;
    #2;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out",       32'(bus.out),       32'd0);
    chk("rst_flags",     32'(bus.flags),     32'd0);
    chk("rst_err",       32'(bus.err),       32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    repeat (2) @(posedge ck);
    #1 rst_n = 1'b1;
    model_reset();

    // MUL_EN=0: both multiply opcodes come back as illegal
    bus0.in_valid = 1'b1; bus0.ctr = 4'b0100; bus0.a = 8'h0F; bus0.b = 8'h11;
    tick();
    bus0.ctr = 4'b0101; bus0.a = 8'hFF; bus0.b = 8'hFF;
    tick();
    bus0.in_valid = 1'b0;
    chk("nomul_mull_ov",    32'(bus0.out_valid), 32'd1);
    chk("nomul_mull_out",   32'(bus0.out),       32'd0);
    chk("nomul_mull_err",   32'(bus0.err),       32'd1);
    chk("nomul_mull_flags", 32'(bus0.flags),     32'(4'b0100));
    tick();
    chk("nomul_mulh_ov",    32'(bus0.out_valid), 32'd1);
    chk("nomul_mulh_out",   32'(bus0.out),       32'd0);
    chk("nomul_mulh_err",   32'(bus0.err),       32'd1);
    chk("nomul_mulh_flags", 32'(bus0.flags),     32'(4'b0100));
    tick();
    chk("nomul_idle", 32'(bus0.out_valid), 32'd0);

    // ADD overflow, one-cycle latency, one-cycle valid
    send(4'b0000, 8'h7F, 8'h01);
    chk("add_lat0", 32'(bus.out_valid), 32'd0);
    tick();
    chk("add_ov",    32'(bus.out_valid), 32'd1);
    chk("add_out",   32'(bus.out),       32'h80);
    chk("add_flags", 32'(bus.flags),     32'(4'b1001));
    tick();
    chk("add_one_cycle", 32'(bus.out_valid), 32'd0);

    // SUB borrow feeding a back-to-back ADC
    send(4'b0001, 8'h00, 8'h01);
    c1 = acc_cyc;
    send(4'b0010, 8'h10, 8'h20);
    chk("b2b_accept", 32'(acc_cyc - c1), 32'd1);
    drain();

    // MULL: in_ready low for W cycles, result at k+W+1
    send(4'b0100, 8'h0F, 8'h11);
    for (int i = 0; i < 8; i++) begin
      chk("mul_busy_ready", 32'(bus.in_ready),  32'd0);
      chk("mul_busy_ov",    32'(bus.out_valid), 32'd0);
      tick();
    end
    chk("mul_done_ready", 32'(bus.in_ready), 32'd1);
    tick();
    chk("mull_ov",    32'(bus.out_valid), 32'd1);
    chk("mull_out",   32'(bus.out),       32'hFF);
    chk("mull_flags", 32'(bus.flags),     32'(4'b1000));
    send(4'b0101, 8'hFF, 8'hFF);
    drain();

    // Shifts/rotates, illegal opcode keeps creg, ADC exposes creg
    send(4'b1110, 8'h81, 8'h00);
    send(4'b1111, 8'h81, 8'h00);
    send(4'b1100, 8'h01, 8'h00);
    send(4'b0110, 8'h55, 8'hAA);
    send(4'b0010, 8'h00, 8'h00);
    drain();

    // Backpressure: AND held in S2, XOR stuck in S1
    bus.out_ready = 1'b0;
    send(4'b1000, 8'hF0, 8'h3C);
    send(4'b1010, 8'hFF, 8'h0F);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_out",      32'(bus.out),       32'h30);
      chk("bp_ov",       32'(bus.out_valid), 32'd1);
      chk("bp_in_ready", 32'(bus.in_ready),  32'd0);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_ready_comb", 32'(bus.in_ready), 32'd1);
    tick();
    chk("bp_next_out", 32'(bus.out),       32'hF0);
    chk("bp_next_ov",  32'(bus.out_valid), 32'd1);
    drain();

    // Reset during a multiply, with creg set beforehand
    send(4'b0001, 8'h00, 8'h01);
    drain();
    send(4'b0100, 8'h5A, 8'h3C);
    repeat (3) tick();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("mrst_ov",       32'(bus.out_valid), 32'd0);
    chk("mrst_out",      32'(bus.out),       32'd0);
    chk("mrst_flags",    32'(bus.flags),     32'd0);
    chk("mrst_err",      32'(bus.err),       32'd0);
    chk("mrst_in_ready", 32'(bus.in_ready),  32'd1);
    #1 rst_n = 1'b1;
    send(4'b0010, 8'h00, 8'h00);
    tick();
    chk("mrst_creg_out",   32'(bus.out),   32'd0);
    chk("mrst_creg_flags", 32'(bus.flags), 32'(4'b0100));
    send(4'b0000, 8'h01, 8'h01);
    tick();
    chk("mrst_add_ov",  32'(bus.out_valid), 32'd1);
    chk("mrst_add_out", 32'(bus.out),       32'h02);
    drain();

    // Randomized ops under random backpressure and issue gaps
    rnd_ready = 1'b1;
    for (int i = 0; i < 80; i++) begin
      send(4'($urandom), 8'($urandom), 8'($urandom));
      if ($urandom_range(0, 3) == 0) tick();
    end
    rnd_ready = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
